dbus_bridge: RTL and testbench
==============================

# dbus_bridge

Data-memory request bridge for the M stage of the pipeline. Converts one load/store per instruction into a two-phase data-bus transaction (address accept, then data return). Drives `d_wait` into the hazard unit, which holds M and bubbles W until the access completes. Byte-lane alignment of store data and sign/zero extension of load data live here, so the pipeline sees 64-bit register values only.

## Interface
Parameters:
- `AW`, 64, address width
- `DW`, 64, data width (fixed at 64; strobe is `DW/8`)

Ports:
- `clk`  in  1  clock; reset is asynchronous and active-high
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  M-stage instruction is a load or store
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  AW  effective address
- `req_size`  in  3  `msize_t`: 0 byte, 1 half, 2 word, 3 dword
- `req_unsigned`  in  1  zero-extend load result
- `req_wdata`  in  DW  store data, right-aligned
- `d_wait`  out  1  M-stage access not yet complete
- `rdata`  out  DW  extended load result, valid while `done`
- `dreq_valid`  out  1  bus request valid
- `dreq_addr`  out  AW  bus address (`req_addr` unchanged)
- `dreq_size`  out  3  bus size (`req_size`)
- `dreq_strobe`  out  8  byte enables; all 0 for loads
- `dreq_data`  out  DW  lane-shifted store data
- `dresp_addr_ok`  in  1  bus accepted address this cycle
- `dresp_data_ok`  in  1  bus returns data / write ack this cycle
- `dresp_data`  in  DW  raw 64-bit bus read data

## Operation
- States: `IDLE`, `ADDR`, `DATA`, `DONE`. Reset → `IDLE`.
- `IDLE`: `req_valid`=1 → `ADDR` (same cycle drives `dreq_valid`=1 combinationally from inputs).
- `ADDR`: `dreq_valid`=1 held with stable fields until `dresp_addr_ok`. `addr_ok` & `data_ok` same cycle → `DONE`; `addr_ok` only → `DATA`.
- `DATA`: `dreq_valid`=0; wait `dresp_data_ok` → `DONE`. `data_ok` captures read data.
- `DONE`: one cycle; `d_wait`=0, `rdata` valid; → `IDLE` unconditionally (next instruction enters M next cycle; no re-issue of the completed one).
- `d_wait = req_valid && state != DONE`.
- Strobe: size 0 → `8'h01 << a`, 1 → `8'h03 << a`, 2 → `8'h0F << a`, 3 → `8'hFF`; `a = req_addr[2:0]`. Loads: strobe 0.
- `dreq_data = req_wdata << (8*a)` (dword: unshifted).
- `rdata`: captured word `>> (8*a)`, truncated to size, sign-extended unless `req_unsigned`; dword passes through.
- Misaligned addresses: no trap; lanes shifted out of range are dropped.
- Once `ADDR` entered, transaction completes even if `req_valid` drops (bus cannot abort); `d_wait` then reads 0.

## Timing
- Reset values: state `IDLE`, `d_wait`=0 (since `req_valid` gated), `dreq_valid`=0, `dreq_strobe`=0, `dreq_data`=0, `rdata`=0.
- Minimum latency: request cycle N with `addr_ok`&`data_ok` → `DONE` N+1, pipeline advances end of N+1. Total 2 cycles of M.
- Request fields must not change while `ADDR`; `req_*` stable because M is stalled.
- Reset mid-transaction: return to `IDLE` immediately, `dreq_valid` deasserts; outstanding bus response after reset ignored.
- `data_ok` in `IDLE`/`ADDR` without prior `addr_ok`: ignored (except combined same-cycle case).

## Structure
- Shared package `common`: `msize_t`, `dbus_req_t`, `dbus_resp_t`, `strobe_t`.
- State enum local to module.
- Combinational sub-module `dbus_align`: strobe generation, store shift, load shift/extend.

## Test plan
- Load word `addr=0x1004`, signed, bus `addr_ok`&`data_ok` cycle 0, data `0x80000001_00000000` → `d_wait` 1 cycle, `rdata=0xFFFFFFFF_80000001`.
- Store byte `addr=0x2003`, `wdata=0xAB`, `addr_ok` after 3 cycles, `data_ok` 2 later → strobe `0x08`, `dreq_data[31:24]=0xAB`, `dreq_valid` held 4 cycles, `d_wait` high 6 cycles.
- Unsigned half load `addr=0x3006`, data `0xFFEE_0000_0000_0000` → `rdata=0xFFEE`.
- Back-to-back loads: second `req_valid` in cycle after `DONE` → new `ADDR`, no duplicate request for first.
- Reset asserted in `DATA` → next edge-independent `dreq_valid`=0, state `IDLE`, later `data_ok` ignored, `d_wait`=0 with `req_valid`=0.

Source files
------------

// File: rtl/dbus_bridge_pkg.sv
// Shared types for the M-stage data-bus bridge: access sizes, strobes and
// the request/response bundles seen on the data bus.
package dbus_bridge_pkg;

  localparam int DBUS_AW = 64;
  localparam int DBUS_DW = 64;
  localparam int DBUS_SW = DBUS_DW / 8;

  typedef enum logic [2:0] {
    MSIZE_B = 3'd0,
    MSIZE_H = 3'd1,
    MSIZE_W = 3'd2,
    MSIZE_D = 3'd3
  } msize_t;

  typedef logic [DBUS_SW-1:0] strobe_t;

  typedef struct packed {
    logic               valid;
    logic [DBUS_AW-1:0] addr;
    msize_t             size;
    strobe_t            strobe;
    logic [DBUS_DW-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic               addr_ok;
    logic               data_ok;
    logic [DBUS_DW-1:0] data;
  } dbus_resp_t;

  // Bit offset of the byte lane selected by the low address bits.
  function automatic logic [5:0] lane_shift(input logic [2:0] addr_lo);
    return {addr_lo, 3'b000};
  endfunction

endpackage

// File: rtl/dbus_bridge_align.sv
// Byte-lane steering: store strobes and data shift, load shift and
// sign/zero extension. Purely combinational.
module dbus_bridge_align
  import dbus_bridge_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [2:0]    addr_lo,
  input  msize_t        size,
  input  logic          is_unsigned,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] raw_rdata,
  output strobe_t       strobe,
  output logic [DW-1:0] wdata_lane,
  output logic [DW-1:0] rdata_ext
);

  logic [DW-1:0] shifted;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    shifted    = raw_rdata >> lane_shift(addr_lo);
    strobe     = '1;
    wdata_lane = wdata;
    rdata_ext  = raw_rdata;
    case (size)
      MSIZE_B: begin
        strobe     = strobe_t'(8'h01) << addr_lo;
        wdata_lane = wdata << lane_shift(addr_lo);
        rdata_ext  = is_unsigned ? DW'(shifted[7:0])
                                 : {{(DW-8){shifted[7]}}, shifted[7:0]};
      end
      MSIZE_H: begin
        strobe     = strobe_t'(8'h03) << addr_lo;
        wdata_lane = wdata << lane_shift(addr_lo);
        rdata_ext  = is_unsigned ? DW'(shifted[15:0])
                                 : {{(DW-16){shifted[15]}}, shifted[15:0]};
      end
      MSIZE_W: begin
        strobe     = strobe_t'(8'h0F) << addr_lo;
        wdata_lane = wdata << lane_shift(addr_lo);
        rdata_ext  = is_unsigned ? DW'(shifted[31:0])
                                 : {{(DW-32){shifted[31]}}, shifted[31:0]};
      end
      default: ;  // dword: full strobe, data passes through unshifted
    endcase
  end

endmodule

// File: rtl/dbus_bridge.sv
// M-stage load/store to two-phase data-bus bridge. Holds the pipeline via
// d_wait until the bus has accepted the address and returned data/ack.
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_size,
  input  logic          req_unsigned,
  input  logic [DW-1:0] req_wdata,
  output logic          d_wait,
  output logic [DW-1:0] rdata,
  output logic          dreq_valid,
  output logic [AW-1:0] dreq_addr,
  output logic [2:0]    dreq_size,
  output logic [7:0]    dreq_strobe,
  output logic [DW-1:0] dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [DW-1:0] dresp_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          issuing;
  logic          capture;
  strobe_t       strobe_al;
  logic [DW-1:0] wdata_al;
  logic [DW-1:0] rdata_al;

  dbus_bridge_align #(.DW(DW)) u_align (
    .addr_lo     (req_addr[2:0]),
    .size        (msize_t'(req_size)),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .raw_rdata   (dresp_data),
    .strobe      (strobe_al),
    .wdata_lane  (wdata_al),
    .rdata_ext   (rdata_al)
  );

  // A new request is presented in IDLE the same cycle req_valid rises, so a
  // bus that accepts and answers at once gives a two-cycle M stage.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    issuing = (state_q == S_IDLE && req_valid) || (state_q == S_ADDR);
    unique case (state_q)
      S_IDLE, S_ADDR: begin
        if (issuing) begin
          if (dresp_addr_ok) state_d = dresp_data_ok ? S_DONE : S_DATA;
          else               state_d = S_ADDR;
        end
      end
      S_DATA:  if (dresp_data_ok) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // data_ok before an address handshake is ignored unless both arrive together.
    capture = ((issuing && dresp_addr_ok) || state_q == S_DATA)
              && dresp_data_ok && !req_write;
    if (capture) rdata_d = rdata_al;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // The request is built combinationally from the stalled M-stage fields;
  // reset forces it quiet without waiting for a clock edge.
  assign dreq_valid  = issuing && !reset;
  assign dreq_addr   = req_addr;
  assign dreq_size   = req_size;
  assign dreq_strobe = (dreq_valid && req_write) ? strobe_al : '0;
  assign dreq_data   = (dreq_valid && req_write) ? wdata_al  : '0;

  assign d_wait = req_valid && (state_q != S_DONE);
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Scoreboard bench for dbus_bridge: the driver queues expected requests and
// completions, a negedge monitor pops and compares them.
module tb_dbus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        d_wait;
  logic [63:0] rdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic        w;
    logic [7:0]  strb;
    logic [63:0] data;
  } req_exp_t;

  typedef struct {
    logic        w;
    logic [63:0] rdata;
  } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];

  dbus_bridge #(.AW(64), .DW(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_wdata     (req_wdata),
    .d_wait        (d_wait),
    .rdata         (rdata),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: request fields are compared when the bus accepts the address,
  // completions when the pipeline sees d_wait drop with a request present.
  always @(negedge clk) begin
    if (!reset) begin
      if (dreq_valid && req_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_req: got request addr 0x%0h expected none", dreq_addr);
      end else if (dreq_valid && dresp_addr_ok) begin
        req_exp_t e;
        e = req_q.pop_front();
        check("req_addr", dreq_addr, e.addr);
        check("req_size", 64'(dreq_size), 64'(e.size));
        check("req_strobe", 64'(dreq_strobe), 64'(e.strb));
        if (e.w) check("req_data", dreq_data, e.data);
      end
      if (req_valid && !d_wait) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_done: got completion expected none");
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_dreq_valid", 64'(dreq_valid), 64'd0);
          if (!d.w) check("load_rdata", rdata, d.rdata);
        end
      end
    end
  end

  // Drives one access; the bus raises addr_ok a_dly cycles after issue and
  // data_ok d_dly cycles after that. Leaves req_valid high on return.
  task automatic do_txn(input logic w, input logic [63:0] addr, input logic [2:0] size,
                        input logic uns, input logic [63:0] wdata,
                        input int a_dly, input int d_dly, input logic [63:0] bus,
                        input logic [7:0] strb, input logic [63:0] exp_wd,
                        input logic [63:0] exp_rd, output int n_wait, output int n_valid);
    bit finished = 1'b0;
    req_q.push_back('{addr, size, w, strb, exp_wd});
    done_q.push_back('{w, exp_rd});
    n_wait  = 0;
    n_valid = 0;
    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    dresp_data   = bus;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      dresp_addr_ok = (k == a_dly);
      dresp_data_ok = (k == a_dly + d_dly);
      @(negedge clk);
      if (!d_wait) begin
        finished = 1'b1;
        break;
      end
      n_wait  += 1;
      n_valid += int'(dreq_valid);
    end
    if (!finished) begin
      n_checks++;
      n_errors++;
      $display("FAIL txn_timeout: got no completion at addr 0x%0h expected one within 40 cycles", addr);
    end
  endtask

  task automatic idle(input int cycles);
    @(posedge clk); #1;
    req_valid     = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int nw, nv;
    reset         = 1'b1;
    req_valid     = 1'b1;
    req_write     = 1'b1;
    req_addr      = 64'h3;
    req_size      = 3'd0;
    req_unsigned  = 1'b0;
    req_wdata     = 64'hFF;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;

    // Reset values, with a store pending on the inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_strobe", 64'(dreq_strobe), 64'd0);
    check("rst_dreq_data", dreq_data, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    req_valid = 1'b0;
    #1;
    check("rst_d_wait", 64'(d_wait), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Signed word load, bus answers immediately.
    do_txn(1'b0, 64'h1004, 3'd2, 1'b0, 64'h0, 0, 0, 64'h80000001_00000000,
           8'h00, 64'h0, 64'hFFFFFFFF_80000001, nw, nv);
    check("lw_wait_cycles", 64'(nw), 64'd1);
    check("lw_valid_cycles", 64'(nv), 64'd1);
    idle(1);

    // Byte store, slow address accept then slow ack.
    do_txn(1'b1, 64'h2003, 3'd0, 1'b0, 64'hAB, 3, 2, 64'h0,
           8'h08, 64'hAB00_0000, 64'h0, nw, nv);
    check("sb_valid_cycles", 64'(nv), 64'd4);
    check("sb_wait_cycles", 64'(nw), 64'd6);
    idle(1);

    do_txn(1'b0, 64'h3006, 3'd1, 1'b1, 64'h0, 1, 1, 64'hFFEE_0000_0000_0000,
           8'h00, 64'h0, 64'hFFEE, nw, nv);
    idle(1);

    // Back-to-back loads: req_valid stays high across the boundary.
    do_txn(1'b0, 64'h0007, 3'd0, 1'b0, 64'h0, 0, 0, 64'h8000_0000_0000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, nw, nv);
    do_txn(1'b0, 64'h0010, 3'd3, 1'b0, 64'h0, 2, 1, 64'h0123_4567_89AB_CDEF,
           8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, nw, nv);
    check("b2b_valid_cycles", 64'(nv), 64'd3);
    check("b2b_wait_cycles", 64'(nw), 64'd4);
    idle(2);

    do_txn(1'b1, 64'h4002, 3'd1, 1'b0, 64'h1234, 0, 1, 64'h0,
           8'h0C, 64'h1234_0000, 64'h0, nw, nv);
    idle(1);
    do_txn(1'b1, 64'h0008, 3'd3, 1'b0, 64'h1122_3344_5566_7788, 1, 0, 64'h0,
           8'hFF, 64'h1122_3344_5566_7788, 64'h0, nw, nv);
    idle(1);
    // Misaligned word store: upper lanes fall off the end.
    do_txn(1'b1, 64'h0006, 3'd2, 1'b0, 64'hDEAD_BEEF, 0, 0, 64'h0,
           8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, nw, nv);
    idle(1);
    do_txn(1'b0, 64'h0007, 3'd1, 1'b0, 64'h0, 0, 2, 64'hAB00_0000_0000_0000,
           8'h00, 64'h0, 64'h00AB, nw, nv);
    idle(1);
    do_txn(1'b0, 64'h0000, 3'd2, 1'b1, 64'h0, 0, 0, 64'hF000_0000,
           8'h00, 64'h0, 64'hF000_0000, nw, nv);
    idle(1);
    do_txn(1'b0, 64'h0000, 3'd2, 1'b0, 64'h0, 0, 0, 64'hF000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_F000_0000, nw, nv);
    idle(1);

    // Reset while waiting for data; the late data_ok must be ignored.
    req_q.push_back('{64'h5000, 3'd2, 1'b0, 8'h00, 64'h0});
    @(posedge clk); #1;
    req_valid     = 1'b1;
    req_write     = 1'b0;
    req_addr      = 64'h5000;
    req_size      = 3'd2;
    req_unsigned  = 1'b0;
    dresp_data    = 64'h1234_5678_9ABC_DEF0;
    dresp_addr_ok = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    check("data_state_valid", 64'(dreq_valid), 64'd0);
    check("data_state_wait", 64'(d_wait), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    req_valid = 1'b0;
    #1;
    check("midrst_d_wait", 64'(d_wait), 64'd0);
    @(posedge clk); #1;
    reset         = 1'b0;
    dresp_data_ok = 1'b1;
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check("late_data_rdata", rdata, 64'd0);
    check("late_data_wait", 64'(d_wait), 64'd0);
    check("late_data_valid", 64'(dreq_valid), 64'd0);

    // A fresh access after reset starts from IDLE.
    do_txn(1'b0, 64'h5001, 3'd0, 1'b1, 64'h0, 0, 0, 64'h0000_0000_0000_C300,
           8'h00, 64'h0, 64'hC3, nw, nv);
    check("post_rst_wait_cycles", 64'(nw), 64'd1);
    idle(3);

    check("req_q_left", 64'(req_q.size()), 64'd0);
    check("done_q_left", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
